id_ex_stage: RTL

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It accepts one RV32I integer instruction per handshake, along with its register-file operands and PC. It decodes the instruction into the ALU's 4-bit operation code and selects the A/B operands. It then holds the result in a valid/ready pipeline register that feeds the ALU and writeback control.

---
 rtl/id_ex_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// RV32I decode-to-execute stage: decodes ALU ops and operands into a valid/ready register.
// Define ID_EX_SKID_EN to build a two-entry main/skid buffer with a registered in_ready.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      3'b111:  base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
    entry_t      e;
    logic        legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    f3    = instr[14:12];
    f7    = instr[31:25];
    legal = 1'b1;
    a     = 32'd0;
    b     = 32'd0;
    op    = OP_ADD;
    case (instr[6:0])
      OPC_REG: begin
        a = rs1;
        b = rs2;
        if (f7 == F7_ZERO) begin
          op = base_op(f3);
        end else if ((f7 == F7_ALT) && (f3 == 3'b000)) begin
          op = OP_SUB;
        end else if ((f7 == F7_ALT) && (f3 == 3'b101)) begin
          op = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_IMM: begin
        a = rs1;
        b = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b001: begin
            if (f7 == F7_ZERO) begin
              op = OP_SLL;
            end else begin
              legal = 1'b0;
            end
          end
          3'b101: begin
            if (f7 == F7_ZERO) begin
              op = OP_SRL;
            end else if (f7 == F7_ALT) begin
              op = OP_SRA;
            end else begin
              legal = 1'b0;
            end
          end
          default: op = base_op(f3);
        endcase
      end
      OPC_LUI: begin
        b = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        a = pc;
        b = {instr[31:12], 12'd0};
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still travel the pipe, but as an inert ADD of zeros.
    e.a         = legal ? a  : 32'd0;
    e.b         = legal ? b  : 32'd0;
    e.op        = legal ? op : OP_ADD;
    e.rd        = instr[11:7];
    e.reg_write = legal && (instr[11:7] != 5'd0);
    e.illegal   = !legal;
    return e;
  endfunction

  entry_t dec_s;
  entry_t main_r;
  logic   main_valid_r;

  // Decode the presented instruction every cycle.
  always_comb begin
    dec_s = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
  end

  assign out_valid = main_valid_r;
  assign alu_a     = main_r.a;
  assign alu_b     = main_r.b;
  assign alu_op    = main_r.op;
  assign rd        = main_r.rd;
  assign reg_write = main_r.reg_write;
  assign illegal   = main_r.illegal;

`ifdef ID_EX_SKID_EN
  entry_t skid_r;
  logic   skid_valid_r;
  logic   in_ready_r;
  logic   in_xfer_s;
  logic   out_xfer_s;

  assign in_ready   = in_ready_r;
  assign in_xfer_s  = in_valid && in_ready_r;
  assign out_xfer_s = main_valid_r && out_ready;

  // Main/skid buffer; in_ready_r tracks "skid empty" one edge ahead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else if (flush) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (skid_valid_r) begin
      if (out_xfer_s) begin
        main_r       <= skid_r;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else begin
        in_ready_r   <= 1'b0;
      end
    end else if (main_valid_r && !out_ready) begin
      if (in_xfer_s) begin
        skid_r       <= dec_s;
        skid_valid_r <= 1'b1;
        in_ready_r   <= 1'b0;
      end else begin
        in_ready_r   <= 1'b1;
      end
    end else begin
      if (in_xfer_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
      in_ready_r <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid_r || out_ready;

  // Single pipeline register: load on accept, empty on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_r       <= '0;
      main_valid_r <= 1'b0;
    end else if (flush) begin
      main_r       <= '0;
      main_valid_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      main_r       <= dec_s;
      main_valid_r <= 1'b1;
    end else if (out_ready) begin
      main_valid_r <= 1'b0;
    end else begin
      main_valid_r <= main_valid_r;
    end
  end
`endif

endmodule
